// File: rtl/instr_bus_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : instr_bus_if                                               |
// | Description : Instruction-memory bus interface between fetch and the     |
// |               instruction bus. Issues word-aligned req/gnt transactions, |
// |               caps in-flight requests at NUM_REQS, returns responses in  |
// |               order and drops responses that belong to pre-flush fetches.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module instr_bus_if #(
    parameter int NUM_REQS = 2
) (
    input  logic        clk,
    input  logic        rstn,
    // fetch side
    input  logic        f_req_i,
    input  logic [31:0] f_addr_i,
    output logic        f_gnt_o,
    output logic        f_rvalid_o,
    output logic [31:0] f_rdata_o,
    output logic        f_err_o,
    input  logic        flush_i,
    // bus side
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    localparam int CNT_W = $clog2(NUM_REQS + 1);
    localparam logic [CNT_W-1:0] c_MAX_OUTSTANDING = CNT_W'(NUM_REQS);
    localparam logic [CNT_W-1:0] c_ONE             = CNT_W'(1);

    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_discard;
    logic [CNT_W-1:0] w_outstanding_nxt;
    logic [CNT_W-1:0] w_discard_nxt;
    logic             w_rsp_valid;
    logic             w_stray_rvalid;
    logic             w_drop;
    logic             w_can_issue;
    logic             w_unused_addr_lsb;

    // A response only counts when something is actually in flight; a stray
    // rvalid with nothing outstanding is ignored entirely.
    assign w_rsp_valid    = mem_rvalid_i & (r_outstanding != '0);
    assign w_stray_rvalid = mem_rvalid_i & (r_outstanding == '0);

    // A same-cycle response frees a slot, so the cap never costs a bubble.
    assign w_can_issue = (r_outstanding < c_MAX_OUTSTANDING) | w_rsp_valid;

    // Request path is purely combinational; fetch holds the address stable.
    assign mem_req_o         = f_req_i & w_can_issue & ~flush_i;
    assign mem_addr_o        = {f_addr_i[31:2], 2'b00};
    assign f_gnt_o           = mem_req_o & mem_gnt_i;
    assign w_unused_addr_lsb = ^f_addr_i[1:0];

    // Responses owed to pre-flush requests are swallowed while discard > 0.
    assign w_drop     = w_rsp_valid & (r_discard != '0);
    assign f_rvalid_o = w_rsp_valid & ~w_drop;
    assign f_rdata_o  = mem_rdata_i;
    assign f_err_o    = mem_err_i & f_rvalid_o;

    // Next-state for the in-flight and discard counters.
    always_comb begin
        w_outstanding_nxt = r_outstanding;
        w_discard_nxt     = r_discard;
        if (f_gnt_o && !w_rsp_valid) begin
            w_outstanding_nxt = r_outstanding + c_ONE;
        end else if (!f_gnt_o && w_rsp_valid) begin
            w_outstanding_nxt = r_outstanding - c_ONE;
        end
        // On flush no grant can happen, so every request still in flight
        // after this cycle's response is marked stale; this re-marks rather
        // than accumulates, keeping discard <= outstanding.
        if (flush_i) begin
            w_discard_nxt = w_outstanding_nxt;
        end else if (w_drop) begin
            w_discard_nxt = r_discard - c_ONE;
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
        end
    end

    // Flag bus protocol violations: a response with nothing outstanding.
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!w_stray_rvalid)
                else $warning("instr_bus_if: stray mem_rvalid_i with no outstanding request");
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_bus_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_instr_bus_if                                            |
// | Description : Self-checking bench for instr_bus_if. A queue of in-flight |
// |               requests, each tagged stale on flush, predicts the outputs.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_instr_bus_if;

    localparam int NUM_REQS = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        f_req_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] f_addr_i, mem_rdata_i;
    logic        f_gnt_o, f_rvalid_o, f_err_o, mem_req_o;
    logic [31:0] f_rdata_o, mem_addr_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } ent_t;
    ent_t q[$];

    // per-cycle expectations from the queue model
    bit          e_req, e_gnt, e_rv, e_err, e_rsp, e_stray;
    logic [31:0] e_addr;

    instr_bus_if #(.NUM_REQS(NUM_REQS)) dut (
        .clk(clk), .rstn(rstn),
        .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o),
        .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o), .f_err_o(f_err_o),
        .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs and predict the combinational outputs.
    task automatic drive(input bit req, input logic [31:0] addr, input bit flush,
                         input bit gnt, input bit rv, input logic [31:0] rdata, input bit err);
        f_req_i = req; f_addr_i = addr; flush_i = flush;
        mem_gnt_i = gnt; mem_rvalid_i = rv; mem_rdata_i = rdata; mem_err_i = err;
        #1;
        e_rsp   = rv && (q.size() > 0);
        e_stray = rv && (q.size() == 0);
        e_req   = req && !flush && ((q.size() < NUM_REQS) || e_rsp);
        e_gnt   = e_req && gnt;
        e_rv    = e_rsp && !q[0].stale;
        e_err   = e_rv && err;
        e_addr  = {addr[31:2], 2'b00};
    endtask

    // Advance the model across the clock edge, then move to the next cycle.
    task automatic tick();
        if (!rstn) begin
            q.delete();
        end else begin
            if (e_rsp) void'(q.pop_front());
            if (e_gnt) q.push_back('{addr: e_addr, stale: 1'b0});
            if (flush_i) foreach (q[i]) q[i].stale = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 32'h0, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle();
        checks++;
        if ({mem_req_o, f_gnt_o, f_rvalid_o, f_err_o} !== 4'b0000) begin
            failures++; $display("FAIL reset_outputs got=%b exp=0000", {mem_req_o, f_gnt_o, f_rvalid_o, f_err_o});
        end
        tick(); tick();
        rstn = 1'b1;
        checks++;
        if (int'(dut.r_outstanding) != 0 || int'(dut.r_discard) != 0) begin
            failures++; $display("FAIL reset_counters out=%0d disc=%0d exp=0/0", dut.r_outstanding, dut.r_discard);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            bit exp_rv;
            exp_rv = (k > 0);
            drive(1, 32'h100 + 32'(4 * k), 0, 1, exp_rv, 32'hD000_0100 + 32'(4 * (k - 1)), 0);
            checks++;
            if (mem_req_o !== 1'b1 || f_gnt_o !== 1'b1 || f_rvalid_o !== exp_rv) begin
                failures++; $display("FAIL b2b_ctrl k=%0d req=%b gnt=%b rv=%b exp=1/1/%b", k, mem_req_o, f_gnt_o, f_rvalid_o, exp_rv);
            end
            if (exp_rv) begin
                checks++;
                if (f_rdata_o !== 32'hD000_0100 + 32'(4 * (k - 1))) begin
                    failures++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, f_rdata_o, 32'hD000_0100 + 32'(4 * (k - 1)));
                end
            end
            tick();
        end
        checks++;
        if (int'(dut.r_outstanding) != 1) begin
            failures++; $display("FAIL b2b_steady out=%0d exp=1", dut.r_outstanding);
        end
        drive(0, 32'h0, 0, 0, 1, 32'hD000_0114, 0);
        checks++;
        if (f_rvalid_o !== 1'b1 || f_rdata_o !== 32'hD000_0114) begin
            failures++; $display("FAIL b2b_drain rv=%b data=%h exp=1/d0000114", f_rvalid_o, f_rdata_o);
        end
        tick();
    endtask

    task automatic test_cap();
        bit exp_req [4] = '{1, 1, 0, 0};
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h300, 0, 1, 0, 32'h0, 0);
            checks++;
            if (mem_req_o !== exp_req[k]) begin
                failures++; $display("FAIL cap_req k=%0d got=%b exp=%b", k, mem_req_o, exp_req[k]);
            end
            tick();
        end
        drive(1, 32'h300, 0, 1, 1, 32'h5555, 0);
        checks++;
        if (mem_req_o !== 1'b1 || f_gnt_o !== 1'b1) begin
            failures++; $display("FAIL cap_reenable req=%b gnt=%b exp=1/1", mem_req_o, f_gnt_o);
        end
        tick();
        checks++;
        if (int'(dut.r_outstanding) != 2) begin
            failures++; $display("FAIL cap_count out=%0d exp=2", dut.r_outstanding);
        end
        repeat (2) begin drive(0, 32'h0, 0, 0, 1, 32'h6666, 0); tick(); end
    endtask

    task automatic test_flush();
        drive(1, 32'h400, 0, 1, 0, 32'h0, 0); tick();
        drive(1, 32'h404, 0, 1, 0, 32'h0, 0); tick();
        drive(1, 32'h408, 1, 1, 0, 32'h0, 0);
        checks++;
        if (mem_req_o !== 1'b0) begin
            failures++; $display("FAIL flush_noreq got=%b exp=0", mem_req_o);
        end
        tick();
        checks++;
        if (int'(dut.r_discard) != 2) begin
            failures++; $display("FAIL flush_discard got=%0d exp=2", dut.r_discard);
        end
        drive(0, 32'h0, 0, 0, 1, 32'hDEAD, 0);
        checks++;
        if (f_rvalid_o !== 1'b0) begin failures++; $display("FAIL flush_drop1 got=%b exp=0", f_rvalid_o); end
        tick();
        drive(0, 32'h0, 0, 0, 1, 32'hBEEF, 1);
        checks++;
        if (f_rvalid_o !== 1'b0 || f_err_o !== 1'b0) begin
            failures++; $display("FAIL flush_drop2 rv=%b err=%b exp=0/0", f_rvalid_o, f_err_o);
        end
        tick();
        drive(1, 32'h200, 0, 1, 0, 32'h0, 0);
        checks++;
        if (f_gnt_o !== 1'b1 || mem_addr_o !== 32'h200) begin
            failures++; $display("FAIL flush_newreq gnt=%b addr=%h exp=1/200", f_gnt_o, mem_addr_o);
        end
        tick();
        drive(0, 32'h0, 0, 0, 1, 32'h1234, 0);
        checks++;
        if (f_rvalid_o !== 1'b1 || f_rdata_o !== 32'h1234) begin
            failures++; $display("FAIL flush_newrsp rv=%b data=%h exp=1/1234", f_rvalid_o, f_rdata_o);
        end
        tick();
    endtask

    task automatic test_flush_with_rvalid();
        drive(1, 32'h500, 0, 1, 0, 32'h0, 0); tick();
        drive(1, 32'h504, 0, 1, 0, 32'h0, 0); tick();
        drive(0, 32'h0, 1, 0, 1, 32'hAAAA, 0);
        checks++;
        if (f_rvalid_o !== 1'b1 || f_rdata_o !== 32'hAAAA) begin
            failures++; $display("FAIL flrv_deliver rv=%b data=%h exp=1/aaaa", f_rvalid_o, f_rdata_o);
        end
        tick();
        checks++;
        if (int'(dut.r_discard) != 1 || int'(dut.r_outstanding) != 1) begin
            failures++; $display("FAIL flrv_counts disc=%0d out=%0d exp=1/1", dut.r_discard, dut.r_outstanding);
        end
        drive(0, 32'h0, 0, 0, 1, 32'hBBBB, 0);
        checks++;
        if (f_rvalid_o !== 1'b0) begin failures++; $display("FAIL flrv_drop got=%b exp=0", f_rvalid_o); end
        tick();
    endtask

    task automatic test_unaligned_err();
        drive(1, 32'h10A, 0, 1, 0, 32'h0, 0);
        checks++;
        if (mem_addr_o !== 32'h108) begin failures++; $display("FAIL unaligned_addr got=%h exp=108", mem_addr_o); end
        tick();
        drive(0, 32'h0, 0, 0, 1, 32'hE0E0, 1);
        checks++;
        if (f_rvalid_o !== 1'b1 || f_err_o !== 1'b1) begin
            failures++; $display("FAIL err_pass rv=%b err=%b exp=1/1", f_rvalid_o, f_err_o);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        drive(1, 32'h600, 0, 1, 0, 32'h0, 0); tick();
        drive(1, 32'h604, 0, 1, 0, 32'h0, 0); tick();
        rstn = 1'b0; idle(); tick(); rstn = 1'b1;
        drive(0, 32'h0, 0, 0, 1, 32'h7777, 0);
        checks++;
        if (f_rvalid_o !== 1'b0 || dut.w_stray_rvalid !== 1'b1) begin
            failures++; $display("FAIL stray_rsp rv=%b flag=%b exp=0/1", f_rvalid_o, dut.w_stray_rvalid);
        end
        tick();
        checks++;
        if (int'(dut.r_outstanding) != 0) begin failures++; $display("FAIL stray_count out=%0d exp=0", dut.r_outstanding); end
    endtask

    task automatic test_random();
        logic [31:0] addr = 32'h8000;
        for (int c = 0; c < 400; c++) begin
            bit rv;
            rv = (q.size() > 0) && ($urandom_range(1, 0) == 1);
            drive($urandom_range(3, 0) != 0, addr | 32'($urandom_range(3, 0)), $urandom_range(9, 0) == 0,
                  $urandom_range(4, 0) < 3, rv, $urandom, $urandom_range(3, 0) == 0);
            checks++;
            if ({mem_req_o, f_gnt_o, f_rvalid_o, f_err_o} !== {e_req, e_gnt, e_rv, e_err} || mem_addr_o !== e_addr) begin
                failures++; $display("FAIL rnd_outputs c=%0d got=%b/%h exp=%b/%h", c,
                    {mem_req_o, f_gnt_o, f_rvalid_o, f_err_o}, mem_addr_o, {e_req, e_gnt, e_rv, e_err}, e_addr);
            end
            if (e_rv) begin
                checks++;
                if (f_rdata_o !== mem_rdata_i) begin failures++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, f_rdata_o, mem_rdata_i); end
            end
            if (e_gnt) addr = addr + 32'h4;
            tick();
            checks++;
            if (int'(dut.r_outstanding) != q.size()) begin
                failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, dut.r_outstanding, q.size());
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_cap();
        test_flush();
        test_flush_with_rvalid();
        test_unaligned_err();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
